// File: rtl/lc3_dmem_arbiter.sv
// Round-robin arbiter and sequencer for the LC3 single-port synchronous data
// memory. Port 0 (core) supports direct and indirect (LDI/STI) access; port 1
// (loader/debug) supports direct access only. One operation in flight.
module lc3_dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [1:0]        p0_mode,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PTR_ISSUE,
    S_PTR_CAPTURE,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic                last_grant, last_grant_n;
  logic                op_port, op_port_n;
  logic [1:0]          op_mode, op_mode_n;
  logic [DATA_W-1:0]   op_wdata, op_wdata_n;
  logic                mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_din_n;
  logic                p0_done_n, p1_done_n;
  logic [DATA_W-1:0]   p0_rdata_n, p1_rdata_n;
  logic                sel;
  logic                fin, fin_rd;

  assign busy = (state != S_IDLE);

  // Next-state, grant selection and next values of all registered outputs.
  // Memory strobes are computed one state ahead so that they appear
  // registered in the cycle of the corresponding state.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    op_port_n    = op_port;
    op_mode_n    = op_mode;
    op_wdata_n   = op_wdata;
    mem_en_n     = 1'b0;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_din_n    = mem_din;
    p0_rdata_n   = p0_rdata;
    p1_rdata_n   = p1_rdata;
    sel          = 1'b0;
    fin          = 1'b0;
    fin_rd       = 1'b0;

    case (state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          sel          = (p0_req && p1_req) ? ~last_grant : p1_req;
          last_grant_n = sel;
          op_port_n    = sel;
          state_n      = S_ISSUE;
          mem_en_n     = 1'b1;
          if (sel) begin
            op_mode_n  = {1'b0, p1_we};
            op_wdata_n = p1_wdata;
            mem_we_n   = p1_we;
            mem_addr_n = p1_addr;
            mem_din_n  = p1_wdata;
          end else begin
            op_mode_n  = p0_mode;
            op_wdata_n = p0_wdata;
            mem_we_n   = (p0_mode == 2'b01);
            mem_addr_n = p0_addr;
            mem_din_n  = p0_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (op_mode == 2'b01) begin
          fin     = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (op_mode[1]) begin
          mem_en_n   = 1'b1;
          mem_we_n   = op_mode[0];
          mem_addr_n = mem_dout[ADDR_W-1:0];
          mem_din_n  = op_wdata;
          state_n    = S_PTR_ISSUE;
        end else begin
          fin     = 1'b1;
          fin_rd  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_PTR_ISSUE: begin
        if (op_mode[0]) begin
          fin     = 1'b1;
          state_n = S_DONE;
        end else begin
          state_n = S_PTR_CAPTURE;
        end
      end
      S_PTR_CAPTURE: begin
        fin     = 1'b1;
        fin_rd  = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    p0_done_n = fin && !op_port;
    p1_done_n = fin && op_port;
    if (fin_rd) begin
      if (op_port) p1_rdata_n = mem_dout;
      else         p0_rdata_n = mem_dout;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_port    <= 1'b0;
      op_mode    <= '0;
      op_wdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      op_port    <= op_port_n;
      op_mode    <= op_mode_n;
      op_wdata   <= op_wdata_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_din    <= mem_din_n;
      p0_done    <= p0_done_n;
      p1_done    <= p1_done_n;
      p0_rdata   <= p0_rdata_n;
      p1_rdata   <= p1_rdata_n;
    end
  end

endmodule

// File: tb/tb_lc3_dmem_arbiter.sv
// Self-checking bench for lc3_dmem_arbiter with a behavioural synchronous
// memory model attached to the memory-side port.
module tb_lc3_dmem_arbiter;

  logic        clock, reset;
  logic        p0_req, p0_done, p1_req, p1_we, p1_done;
  logic [1:0]  p0_mode;
  logic [15:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_din, mem_dout;

  logic [15:0] mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  int n_chk, n_fail;

  typedef struct {
    logic        port;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ptr;
    int          lat;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [7];

  lc3_dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_mode(p0_mode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port memory; the preload path is used only under reset.
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  // Issue one operation from IDLE, follow it to its done pulse, drop req.
  task automatic do_op(input string nm, input vec_t v);
    int lat;
    lat = 0;
    if (!v.port) begin
      p0_req = 1'b1; p0_mode = v.mode; p0_addr = v.addr; p0_wdata = v.wdata;
    end else begin
      p1_req = 1'b1; p1_we = v.mode[0]; p1_addr = v.addr; p1_wdata = v.wdata;
    end
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      tick();
      if (k == 1) begin
        chk({nm, "_c1_en"}, mem_en, 1);
        chk({nm, "_c1_addr"}, mem_addr, v.addr);
        chk({nm, "_c1_we"}, mem_we, (v.mode == 2'b01));
        if (v.mode == 2'b01) chk({nm, "_c1_din"}, mem_din, v.wdata);
      end
      if (k == 2) chk({nm, "_c2_en"}, mem_en, 0);
      if (k == 3 && v.mode[1]) begin
        chk({nm, "_c3_en"}, mem_en, 1);
        chk({nm, "_c3_ptr"}, mem_addr, v.ptr);
        chk({nm, "_c3_we"}, mem_we, v.mode[0]);
        if (v.mode[0]) chk({nm, "_c3_din"}, mem_din, v.wdata);
      end
      chk({nm, "_other_done"}, v.port ? p0_done : p1_done, 0);
      if (v.port ? p1_done : p0_done) begin
        lat = k;
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_rdata"}, v.port ? p1_rdata : p0_rdata, v.rd);
    tick();
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_done_clr"}, v.port ? p1_done : p0_done, 0);
  endtask

  initial begin
    logic d0 [1:17];
    logic d1 [1:17];
    logic bz [1:17];
    int   c0, c1, t0, t1, tb1;
    vec_t v;

    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    p0_req = 0; p0_mode = '0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    pre_we = 1'b1; pre_addr = 16'h4000; pre_data = 16'h5000;

    vecs[0] = '{1'b0, 2'b01, 16'h3000, 16'hBEEF, 16'h0000, 2, 16'h0000};
    vecs[1] = '{1'b0, 2'b00, 16'h3000, 16'h0000, 16'h0000, 3, 16'hBEEF};
    vecs[2] = '{1'b0, 2'b10, 16'h4000, 16'h0000, 16'h5000, 5, 16'h1234};
    vecs[3] = '{1'b0, 2'b11, 16'h4000, 16'hA5A5, 16'h5000, 4, 16'h1234};
    vecs[4] = '{1'b1, 2'b01, 16'h0010, 16'h7777, 16'h0000, 2, 16'h0000};
    vecs[5] = '{1'b1, 2'b00, 16'h0010, 16'h0000, 16'h0000, 3, 16'h7777};
    vecs[6] = '{1'b0, 2'b00, 16'h3000, 16'h0000, 16'h0000, 3, 16'hBEEF};

    tick();
    pre_addr = 16'h5000; pre_data = 16'h1234;
    tick();
    pre_we = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_done", p1_done, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_op($sformatf("vec%0d", i), vecs[i]);
    chk("mem_5000_sti", mem[16'h5000], 16'hA5A5);
    chk("mem_4000_kept", mem[16'h4000], 16'h5000);
    chk("mem_0010_p1", mem[16'h0010], 16'h7777);

    // Round robin with both ports requesting continuously from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0_req = 1; p0_mode = 2'b00; p0_addr = 16'h3000;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0010;
    for (int k = 1; k <= 17; k++) begin
      tick();
      d0[k] = p0_done; d1[k] = p1_done; bz[k] = busy;
    end
    p0_req = 0; p1_req = 0;
    wait_idle("rr");
    c0 = 0; c1 = 0;
    for (int k = 1; k <= 17; k++) begin
      c0 += int'(d0[k]); c1 += int'(d1[k]);
      if (d0[k] && d1[k]) chk("rr_overlap", 1, 0);
    end
    chk("rr_p0_count", c0, 2);
    chk("rr_p1_count", c1, 2);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_g%0d_p0", j), d0[3 + 4*j], (j % 2) == 0);
      chk($sformatf("rr_g%0d_p1", j), d1[3 + 4*j], (j % 2) == 1);
      if (j < 3) begin
        chk($sformatf("rr_g%0d_gap", j), bz[4 + 4*j], 0);
        chk($sformatf("rr_g%0d_regrant", j), bz[5 + 4*j], 1);
      end
    end
    chk("rr_p0_rdata", p0_rdata, 16'hBEEF);
    chk("rr_p1_rdata", p1_rdata, 16'h7777);

    // p1 arrives while p0 indirect read is in progress.
    t0 = 0; t1 = 0;
    p0_req = 1; p0_mode = 2'b10; p0_addr = 16'h4000;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) begin p1_req = 1; p1_we = 0; p1_addr = 16'h3000; end
      if (p0_done) begin
        t0 = k; p0_req = 0;
        chk("ovl_p0_rdata", p0_rdata, 16'hA5A5);
      end
      if (p1_done) begin t1 = k; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    chk("ovl_p0_done_cyc", t0, 5);
    chk("ovl_p1_done_cyc", t1, 9);
    chk("ovl_p1_rdata", p1_rdata, 16'hBEEF);
    chk("ovl_p0_rdata_kept", p0_rdata, 16'hA5A5);
    wait_idle("ovl");

    // Reset lands before the pointer write of an indirect write.
    p0_req = 1; p0_mode = 2'b11; p0_addr = 16'h4000; p0_wdata = 16'h0BAD;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_din", mem_din, 0);
    chk("abort_p0_done", p0_done, 0);
    chk("abort_p0_rdata", p0_rdata, 0);
    chk("abort_p1_rdata", p1_rdata, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    p0_req = 0;
    c0 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      c0 += int'(p0_done);
    end
    chk("abort_no_done", c0, 0);
    chk("abort_mem_kept", mem[16'h5000], 16'hA5A5);
    v = '{1'b0, 2'b00, 16'h3000, 16'h0000, 16'h0000, 3, 16'hBEEF};
    do_op("post_abort", v);

    // req held one cycle past done starts a second operation.
    p0_req = 1; p0_mode = 2'b01; p0_addr = 16'h3001; p0_wdata = 16'h1111;
    t0 = 0;
    for (int k = 1; k <= 8 && t0 == 0; k++) begin
      tick();
      if (p0_done) t0 = k;
    end
    chk("hold_first_done", t0, 2);
    tick();
    chk("hold_idle_busy", busy, 0);
    tick();
    tb1 = int'(mem_en);
    chk("hold_reissue_en", tb1, 1);
    chk("hold_reissue_addr", mem_addr, 16'h3001);
    chk("hold_reissue_we", mem_we, 1);
    p0_req = 0;
    tick();
    chk("hold_second_done", p0_done, 1);
    wait_idle("hold");
    chk("hold_mem", mem[16'h3001], 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
